// File: rtl/cdc_tx_arbiter.sv
// Round-robin arbiter that hands one payload at a time to another clock domain
// over a four-phase req/ack handshake. Define CDC_ARB_TIMEOUT_EN to build the ack-wait timeout.
module cdc_tx_arbiter #(
  parameter int N_REQ          = 4,
  parameter int WIDTH          = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*WIDTH-1:0]     req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       xfer_req,
  output logic [WIDTH-1:0]           xfer_data,
  input  logic                       xfer_ack,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       err
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int SUM_W = IDX_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_REL
  } state_t;

  // Elaboration-time parameter sanity checks.
  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
    $error("cdc_tx_arbiter: N_REQ must be 2..8");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("cdc_tx_arbiter: SYNC_STAGES must be at least 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("cdc_tx_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  state_t                   state;
  logic [IDX_W-1:0]         rr_ptr;
  logic [SYNC_STAGES-1:0]   ack_sync;
  logic                     ack_s;
  logic                     timeout;

  logic [WIDTH-1:0]         payload [N_REQ];
  logic [N_REQ-1:0]         rot;
  logic [IDX_W-1:0]         grant_off;
  logic [SUM_W-1:0]         grant_sum;
  logic [IDX_W-1:0]         grant_idx;
  logic                     grant_any;

  for (genvar g = 0; g < N_REQ; g++) begin : g_payload
    assign payload[g] = req_data[g*WIDTH +: WIDTH];
  end

  // ack crosses domains: plain multi-flop synchronizer, oldest bit is ack_s.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_sync <= '0;
    end else begin
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], xfer_ack};
    end
  end

  assign ack_s = ack_sync[SYNC_STAGES-1];

  // Round-robin pick: rotate so rr_ptr sits at bit 0, take the lowest set bit,
  // then rotate the offset back into an absolute requester index.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rot       = N_REQ'({req_valid, req_valid} >> rr_ptr);
    grant_off = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) grant_off = IDX_W'(k);
    end
    grant_sum = {1'b0, rr_ptr} + {1'b0, grant_off};
    if (grant_sum >= SUM_W'(N_REQ)) grant_sum = grant_sum - SUM_W'(N_REQ);
    grant_idx = grant_sum[IDX_W-1:0];
    grant_any = |req_valid;
  end

  // Accept strobe is combinational so a requester is taken in its first IDLE cycle;
  // rst_n gates it so nothing looks accepted while reset is held.
  always_comb begin
    req_ready = '0;
    if (rst_n && state == ST_IDLE && grant_any) req_ready[grant_idx] = 1'b1;
  end

  assign busy = (state != ST_IDLE);

`ifdef CDC_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt;
  logic             err_q;

  // Counts REQ cycles; restarts from zero on every entry into REQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state == ST_REQ) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      tmo_cnt <= '0;
    end
  end

  assign timeout = (state == ST_REQ) && !ack_s &&
                   (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (timeout) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      xfer_req  <= 1'b0;
      xfer_data <= '0;
      grant_id  <= '0;
      rr_ptr    <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (grant_any) begin
            xfer_data <= payload[grant_idx];
            grant_id  <= grant_idx;
            rr_ptr    <= (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
            xfer_req  <= 1'b1;
            state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (ack_s || timeout) begin
            xfer_req <= 1'b0;
            state    <= ST_REL;
          end
        end
        ST_REL: begin
          // Wait for the destination to release ack before starting another transfer.
          if (!ack_s) state <= ST_IDLE;
        end
        default: begin
          xfer_req <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cdc_tx_arbiter.sv
// Directed bench for cdc_tx_arbiter: handshake latency, round-robin order,
// busy hold-off, dropped requests, ack glitch, async reset and timeout.
module tb_cdc_tx_arbiter;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int TMO = 10;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           xfer_req;
  logic [W-1:0]   xfer_data;
  logic           xfer_ack = 1'b0;
  logic           busy;
  logic [1:0]     grant_id;
  logic           err;

  int n_cmp  = 0;
  int n_fail = 0;

  cdc_tx_arbiter #(
    .N_REQ(N), .WIDTH(W), .SYNC_STAGES(2), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .xfer_req(xfer_req), .xfer_data(xfer_data),
    .xfer_ack(xfer_ack), .busy(busy), .grant_id(grant_id), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst_n     = 1'b0;
    req_valid = '0;
    xfer_ack  = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    #1;
  endtask

  // Completes the handshake of the transfer in flight, with bounded waits.
  task automatic finish_xfer(input string tag);
    int i;
    xfer_ack = 1'b1;
    i = 0;
    while (xfer_req === 1'b1 && i < 20) begin tick; i++; end
    n_cmp++;
    if (xfer_req !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_req_fall: xfer_req=%b after %0d cycles, want 0", tag, xfer_req, i);
    end
    xfer_ack = 1'b0;
    i = 0;
    while (busy === 1'b1 && i < 20) begin tick; i++; end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_busy_fall: busy=%b after %0d cycles, want 0", tag, busy, i);
    end
  endtask

  task automatic test_reset;
    req_valid = 4'b0001;
    #3;
    n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_ready: got %b want 0000", req_ready); end
    n_cmp++; if (xfer_req !== 1'b0) begin n_fail++; $display("FAIL rst_xfer_req: got %b want 0", xfer_req); end
    n_cmp++; if (xfer_data !== 8'h00) begin n_fail++; $display("FAIL rst_xfer_data: got %h want 00", xfer_data); end
    n_cmp++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL rst_grant_id: got %0d want 0", grant_id); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", err); end
    apply_reset;
  endtask

  task automatic test_single;
    req_data  = {8'h44, 8'hA5, 8'h22, 8'h11};
    req_valid = 4'b0100;
    #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready: got %b want 0100", req_ready); end
    tick;
    n_cmp++; if (xfer_req !== 1'b1) begin n_fail++; $display("FAIL single_req_rise: got %b want 1", xfer_req); end
    n_cmp++; if (xfer_data !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h want a5", xfer_data); end
    n_cmp++; if (grant_id !== 2'd2) begin n_fail++; $display("FAIL single_grant: got %0d want 2", grant_id); end
    n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL single_ready_one_cycle: got %b want 0000", req_ready); end
    req_valid = '0;
    xfer_ack  = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick;
      n_cmp++;
      if (xfer_req !== (k < 3)) begin
        n_fail++;
        $display("FAIL single_ack_latency: edge +%0d xfer_req=%b want %b", k, xfer_req, (k < 3));
      end
    end
    xfer_ack = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick;
      n_cmp++;
      if (busy !== (k < 3)) begin
        n_fail++;
        $display("FAIL single_release_latency: edge +%0d busy=%b want %b", k, busy, (k < 3));
      end
    end
  endtask

  task automatic test_round_robin;
    logic [7:0] exp_pl [4];
    logic [3:0] exp_ready;
    int         exp;
    exp_pl = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
    apply_reset;
    req_data  = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    req_valid = 4'hF;
    for (int n = 0; n < 5; n++) begin
      exp       = n % 4;
      exp_ready = 4'(1 << exp);
      #1;
      n_cmp++; if (req_ready !== exp_ready) begin n_fail++; $display("FAIL rr_ready[%0d]: got %b want %b", n, req_ready, exp_ready); end
      tick;
      n_cmp++; if (grant_id !== 2'(exp)) begin n_fail++; $display("FAIL rr_grant[%0d]: got %0d want %0d", n, grant_id, exp); end
      n_cmp++; if (xfer_data !== exp_pl[exp]) begin n_fail++; $display("FAIL rr_data[%0d]: got %h want %h", n, xfer_data, exp_pl[exp]); end
      finish_xfer("rr");
    end
    req_valid = '0;
  endtask

  // Last grant was 0, so the pointer is at 1.
  task automatic test_busy_holdoff;
    int i;
    req_data  = {8'h4D, 8'h3C, 8'h2B, 8'h1A};
    req_valid = 4'b0001;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL hold_first_ready: got %b want 0001", req_ready); end
    tick;
    req_valid = 4'b0010;
    #1;
    n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL hold_in_req: got %b want 0000", req_ready); end
    xfer_ack = 1'b1;
    i = 0;
    while (i < 20) begin
      tick;
      i++;
      if (xfer_req === 1'b0) xfer_ack = 1'b0;
      if (busy !== 1'b1) break;
      n_cmp++;
      if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL hold_busy_ready: cycle %0d got %b want 0000", i, req_ready); end
    end
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL hold_idle: busy=%b after %0d cycles want 0", busy, i); end
    n_cmp++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL hold_release_ready: got %b want 0010", req_ready); end
    tick;
    n_cmp++; if (grant_id !== 2'd1) begin n_fail++; $display("FAIL hold_grant: got %0d want 1", grant_id); end
    n_cmp++; if (xfer_data !== 8'h2B) begin n_fail++; $display("FAIL hold_data: got %h want 2b", xfer_data); end
    req_valid = '0;
    finish_xfer("hold");
  endtask

  // Pointer at 2: requester 2 asks, withdraws while busy, so 3 must win.
  task automatic test_drop_before_accept;
    req_valid = 4'b0001;
    tick;
    n_cmp++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL drop_first_grant: got %0d want 0", grant_id); end
    req_valid = 4'b0100;
    xfer_ack  = 1'b1;
    tick;
    tick;
    req_valid = 4'b1000;
    finish_xfer("drop");
    n_cmp++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL drop_ready: got %b want 1000", req_ready); end
    tick;
    n_cmp++; if (grant_id !== 2'd3) begin n_fail++; $display("FAIL drop_grant: got %0d want 3", grant_id); end
    n_cmp++; if (xfer_data !== 8'h4D) begin n_fail++; $display("FAIL drop_data: got %h want 4d", xfer_data); end
    req_valid = '0;
    finish_xfer("drop2");
  endtask

  task automatic test_glitch;
    req_valid = 4'b0001;
    tick;
    req_valid = '0;
    xfer_ack  = 1'b1;
    tick;
    xfer_ack = 1'b0;
    n_cmp++; if (xfer_req !== 1'b1) begin n_fail++; $display("FAIL glitch_e1: xfer_req=%b want 1", xfer_req); end
    tick;
    n_cmp++; if (xfer_req !== 1'b1) begin n_fail++; $display("FAIL glitch_e2: xfer_req=%b want 1", xfer_req); end
    tick;
    n_cmp++; if (xfer_req !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL glitch_rel: xfer_req=%b busy=%b want 0 1", xfer_req, busy); end
    tick;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_idle: busy=%b want 0", busy); end
  endtask

  // Pointer at 1 after the glitch transfer, so requester 1 is granted first.
  task automatic test_reset_mid;
    req_valid = 4'b0010;
    tick;
    req_valid = 4'hF;
    n_cmp++; if (xfer_req !== 1'b1) begin n_fail++; $display("FAIL mid_pre: xfer_req=%b want 1", xfer_req); end
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (xfer_req !== 1'b0) begin n_fail++; $display("FAIL mid_xfer_req: got %b want 0", xfer_req); end
    n_cmp++; if (xfer_data !== 8'h00) begin n_fail++; $display("FAIL mid_xfer_data: got %h want 00", xfer_data); end
    n_cmp++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL mid_grant_id: got %0d want 0", grant_id); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", busy); end
    n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL mid_ready: got %b want 0000", req_ready); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL mid_err: got %b want 0", err); end
    tick;
    rst_n = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_prio0: got %b want 0001", req_ready); end
    tick;
    n_cmp++; if (xfer_data !== 8'h1A) begin n_fail++; $display("FAIL mid_regrant_data: got %h want 1a", xfer_data); end
    req_valid = '0;
    finish_xfer("mid");
  endtask

  // Pointer at 1: requester 2 is granted, ack never comes.
  task automatic test_timeout;
    req_valid = 4'b0100;
    tick;
    req_valid = '0;
    n_cmp++; if (grant_id !== 2'd2) begin n_fail++; $display("FAIL tmo_grant: got %0d want 2", grant_id); end
`ifdef CDC_ARB_TIMEOUT_EN
    repeat (TMO - 1) tick;
    n_cmp++; if (xfer_req !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL tmo_early: xfer_req=%b err=%b want 1 0", xfer_req, err); end
    tick;
    n_cmp++; if (xfer_req !== 1'b0 || err !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL tmo_fire: xfer_req=%b err=%b busy=%b want 0 1 1", xfer_req, err, busy); end
    tick;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL tmo_idle: busy=%b want 0", busy); end
    req_valid = 4'b0001;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL tmo_next_ready: got %b want 0001", req_ready); end
    tick;
    req_valid = '0;
    finish_xfer("tmo_next");
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: err=%b want 1", err); end
`else
    repeat (2 * TMO) tick;
    n_cmp++; if (xfer_req !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL notmo_wait: xfer_req=%b err=%b want 1 0", xfer_req, err); end
    finish_xfer("notmo");
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL notmo_err: err=%b want 0", err); end
`endif
  endtask

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_busy_holdoff;
    test_drop_before_accept;
    test_glitch;
    test_reset_mid;
    test_timeout;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
